// File: rtl/if_stage.sv
// Instruction fetch stage: PC register, IF/ID pipeline register, halt flag, fetch counter.
// Ports: clk/reset (sync, active-high); imem_addr_o/imem_dout_i async instruction memory;
//   stall/flush/redirect_valid/redirect_pc/halt hazard and control inputs;
//   if_id_* pipeline register outputs; halted sticky flag; fetch_count valid-fetch counter.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_dout,
  input  logic        stall,
  input  logic        flush,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_pc_plus4,
  output logic [31:0] if_id_inst,
  output logic        if_id_valid,
  output logic        halted,
  output logic [31:0] fetch_count
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] if_id_pc_q, if_id_pc_d;
  logic [31:0] if_id_pc_plus4_q, if_id_pc_plus4_d;
  logic [31:0] if_id_inst_q, if_id_inst_d;
  logic        if_id_valid_q, if_id_valid_d;
  logic        halted_q, halted_d;
  logic [31:0] fetch_count_q, fetch_count_d;
  logic [31:0] pc_plus4;

  // Wraps modulo 2^32 naturally.
  assign pc_plus4 = pc_q + 32'd4;

  // Next PC: redirect beats halt beats stall beats sequential.
  always_comb begin
    pc_d = pc_plus4;
    if (redirect_valid) begin
      pc_d = {redirect_pc[31:2], 2'b00};
    end else if (halted_q || halt) begin
      pc_d = pc_q;
    end else if (stall) begin
      pc_d = pc_q;
    end
  end

  // IF/ID update. A redirect kills the wrong-path word currently being fetched,
  // which is exactly one bubble. Flush wins over stall. Halt raised this cycle
  // still lets the current fetch through; bubbles start once halted_q is set.
  always_comb begin
    if_id_pc_d       = if_id_pc_q;
    if_id_pc_plus4_d = if_id_pc_plus4_q;
    if_id_inst_d     = if_id_inst_q;
    if_id_valid_d    = if_id_valid_q;
    fetch_count_d    = fetch_count_q;
    if (flush || redirect_valid) begin
      if_id_inst_d  = NOP_INST;
      if_id_valid_d = 1'b0;
    end else if (stall) begin
      // hold everything
    end else if (halted_q) begin
      if_id_inst_d  = NOP_INST;
      if_id_valid_d = 1'b0;
    end else begin
      if_id_pc_d       = pc_q;
      if_id_pc_plus4_d = pc_plus4;
      if_id_inst_d     = imem_dout;
      if_id_valid_d    = 1'b1;
      fetch_count_d    = fetch_count_q + 32'd1;
    end
  end

  // A same-cycle redirect cancels the halt request.
  assign halted_d = halted_q || (halt && !redirect_valid);

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q             <= RESET_PC;
      if_id_pc_q       <= 32'h0;
      if_id_pc_plus4_q <= 32'h0;
      if_id_inst_q     <= NOP_INST;
      if_id_valid_q    <= 1'b0;
      halted_q         <= 1'b0;
      fetch_count_q    <= 32'h0;
    end else begin
      pc_q             <= pc_d;
      if_id_pc_q       <= if_id_pc_d;
      if_id_pc_plus4_q <= if_id_pc_plus4_d;
      if_id_inst_q     <= if_id_inst_d;
      if_id_valid_q    <= if_id_valid_d;
      halted_q         <= halted_d;
      fetch_count_q    <= fetch_count_d;
    end
  end

  assign imem_addr      = pc_q;
  assign if_id_pc       = if_id_pc_q;
  assign if_id_pc_plus4 = if_id_pc_plus4_q;
  assign if_id_inst     = if_id_inst_q;
  assign if_id_valid    = if_id_valid_q;
  assign halted         = halted_q;
  assign fetch_count    = fetch_count_q;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: sequential fetch, stall, redirect+stall, flush over stall,
// PC wrap, halt then reset. Instruction memory is a combinational tag of the address.
module tb_if_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] imem_addr;
  logic [31:0] imem_dout;
  logic        stall;
  logic        flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_pc_plus4;
  logic [31:0] if_id_inst;
  logic        if_id_valid;
  logic        halted;
  logic [31:0] fetch_count;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] inst_at(input logic [31:0] a);
    return 32'hA500_0000 ^ a;
  endfunction

  assign imem_dout = inst_at(imem_addr);

  if_stage dut (
    .clk           (clk),
    .reset         (reset),
    .imem_addr     (imem_addr),
    .imem_dout     (imem_dout),
    .stall         (stall),
    .flush         (flush),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .halt          (halt),
    .if_id_pc      (if_id_pc),
    .if_id_pc_plus4(if_id_pc_plus4),
    .if_id_inst    (if_id_inst),
    .if_id_valid   (if_id_valid),
    .halted        (halted),
    .fetch_count   (fetch_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; flush = 1'b0; redirect_valid = 1'b0;
    redirect_pc = 32'h0; halt = 1'b0;

    // Reset state
    step(); step();
    check("rst_addr",  imem_addr, 32'h0);
    check("rst_valid", {31'b0, if_id_valid}, 32'd0);
    check("rst_inst",  if_id_inst, NOP);
    check("rst_pc",    if_id_pc, 32'h0);
    check("rst_halt",  {31'b0, halted}, 32'd0);
    check("rst_cnt",   fetch_count, 32'd0);

    // Sequential fetch: first entry one cycle after reset release
    reset = 1'b0;
    step();
    check("seq0_pc",   if_id_pc, 32'h0);
    check("seq0_inst", if_id_inst, inst_at(32'h0));
    check("seq0_vld",  {31'b0, if_id_valid}, 32'd1);
    check("seq0_p4",   if_id_pc_plus4, 32'h4);
    step();
    check("seq1_pc",   if_id_pc, 32'h4);
    check("seq1_inst", if_id_inst, inst_at(32'h4));
    check("seq1_addr", imem_addr, 32'h8);

    // Stall two cycles at PC=0x8
    stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      check("stl_addr", imem_addr, 32'h8);
      check("stl_pc",   if_id_pc, 32'h4);
      check("stl_vld",  {31'b0, if_id_valid}, 32'd1);
      check("stl_cnt",  fetch_count, 32'd2);
    end
    stall = 1'b0;
    step();
    check("seq2_pc",   if_id_pc, 32'h8);
    check("seq2_inst", if_id_inst, inst_at(32'h8));
    step();
    check("seq3_pc",   if_id_pc, 32'hC);
    check("seq3_inst", if_id_inst, inst_at(32'hC));
    check("seq3_cnt",  fetch_count, 32'd4);
    check("seq3_addr", imem_addr, 32'h10);

    // Redirect with simultaneous stall, target low bits cleared
    redirect_valid = 1'b1; redirect_pc = 32'h43; stall = 1'b1;
    step();
    redirect_valid = 1'b0; stall = 1'b0;
    check("rd_addr", imem_addr, 32'h40);
    check("rd_vld",  {31'b0, if_id_valid}, 32'd0);
    check("rd_inst", if_id_inst, NOP);
    check("rd_pc",   if_id_pc, 32'hC);
    check("rd_cnt",  fetch_count, 32'd4);
    step();
    check("rd2_pc",   if_id_pc, 32'h40);
    check("rd2_vld",  {31'b0, if_id_valid}, 32'd1);
    check("rd2_inst", if_id_inst, inst_at(32'h40));
    check("rd2_p4",   if_id_pc_plus4, 32'h44);
    check("rd2_cnt",  fetch_count, 32'd5);

    // Flush beats stall on IF/ID; PC held by stall
    flush = 1'b1; stall = 1'b1;
    step();
    flush = 1'b0; stall = 1'b0;
    check("fl_vld",  {31'b0, if_id_valid}, 32'd0);
    check("fl_inst", if_id_inst, NOP);
    check("fl_addr", imem_addr, 32'h44);
    check("fl_pc",   if_id_pc, 32'h40);
    check("fl_cnt",  fetch_count, 32'd5);

    // Wrap at top of address space
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect_valid = 1'b0;
    check("wr_addr", imem_addr, 32'hFFFF_FFFC);
    step();
    check("wr_pc",   if_id_pc, 32'hFFFF_FFFC);
    check("wr_p4",   if_id_pc_plus4, 32'h0);
    check("wr_addr2", imem_addr, 32'h0);
    check("wr_cnt",  fetch_count, 32'd6);
    step();
    check("wr2_pc",  if_id_pc, 32'h0);
    check("wr2_cnt", fetch_count, 32'd7);

    // Halt request cancelled by a same-cycle redirect to 0x10
    redirect_valid = 1'b1; redirect_pc = 32'h10; halt = 1'b1;
    step();
    redirect_valid = 1'b0; halt = 1'b0;
    check("hr_halt", {31'b0, halted}, 32'd0);
    check("hr_addr", imem_addr, 32'h10);

    // Halt at PC=0x10
    halt = 1'b1;
    step();
    halt = 1'b0;
    check("h_halt", {31'b0, halted}, 32'd1);
    check("h_addr", imem_addr, 32'h10);
    check("h_pc",   if_id_pc, 32'h10);
    check("h_cnt",  fetch_count, 32'd8);
    for (int i = 0; i < 3; i++) begin
      step();
      check("hf_vld",  {31'b0, if_id_valid}, 32'd0);
      check("hf_addr", imem_addr, 32'h10);
      check("hf_halt", {31'b0, halted}, 32'd1);
      check("hf_cnt",  fetch_count, 32'd8);
    end

    // Reset out of halt, with stall asserted too
    reset = 1'b1; stall = 1'b1;
    step();
    check("hr_rst_addr", imem_addr, 32'h0);
    check("hr_rst_halt", {31'b0, halted}, 32'd0);
    check("hr_rst_cnt",  fetch_count, 32'd0);
    check("hr_rst_vld",  {31'b0, if_id_valid}, 32'd0);
    reset = 1'b0; stall = 1'b0;
    step();
    check("re_pc",   if_id_pc, 32'h0);
    check("re_vld",  {31'b0, if_id_valid}, 32'd1);
    check("re_cnt",  fetch_count, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the PC value loaded on reset.
REQ-002 SHALL have parameter NOP_INST, default 32'h0000_0013, meaning the instruction word inserted as a bubble (addi x0,x0,0).
REQ-003 SHALL have port clk, input, 1, the clock; all state updates on posedge clk.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port imem_addr, output, 32, the byte address driven to instruction memory; equals the current PC combinationally.
REQ-006 SHALL have port imem_dout, input, 32, the instruction returned asynchronously by instruction memory for imem_addr in the same cycle.
REQ-007 SHALL have port stall, input, 1, the load-use hazard hold: freeze PC and IF/ID.
REQ-008 SHALL have port flush, input, 1, the control hazard kill: the IF/ID entry becomes a bubble.
REQ-009 SHALL have port redirect_valid, input, 1, the taken-branch/jump correction from EX.
REQ-010 SHALL have port redirect_pc, input, 32, the corrected target address.
REQ-011 SHALL have port halt, input, 1, the ecall/halt request; freezes fetch permanently until reset.
REQ-012 SHALL have port if_id_pc, output, 32, the PC of the instruction held in IF/ID.
REQ-013 SHALL have port if_id_pc_plus4, output, 32, if_id_pc + 4.
REQ-014 SHALL have port if_id_inst, output, 32, the instruction word held in IF/ID.
REQ-015 SHALL have port if_id_valid, output, 1, 1 when IF/ID holds a real instruction, 0 for a bubble.
REQ-016 SHALL have port halted, output, 1, a sticky flag set by halt.
REQ-017 SHALL have port fetch_count, output, 32, the number of instructions accepted into IF/ID with valid=1.

Function
REQ-018 SHALL keep PC in a 32-bit register; imem_addr SHALL equal PC at all times, including during reset.
REQ-019 SHALL compute the next PC with this priority: redirect_valid (redirect_pc with bits [1:0] forced to 0) > halted or halt (hold) > stall (hold) > PC+4.
REQ-020 SHALL wrap PC+4 modulo 2^32 (32'hFFFF_FFFC + 4 -> 32'h0000_0000), with no error flag.
REQ-021 SHALL update IF/ID with this priority: flush or redirect_valid -> {inst=NOP_INST, valid=0, pc/pc_plus4 hold} > stall -> hold all fields > halted -> {inst=NOP_INST, valid=0} > otherwise {pc=PC, pc_plus4=PC+4, inst=imem_dout, valid=1}.
REQ-022 SHALL give a fetch-to-IF/ID latency of exactly 1 cycle: the word read at PC in cycle n appears on if_id_inst in cycle n+1.
REQ-023 SHALL produce exactly one bubble for redirect_valid in cycle n: the target is fetched in cycle n+1 and is valid in IF/ID in cycle n+2.
REQ-024 SHALL let flush override stall in the same cycle for IF/ID, while PC follows REQ-019.
REQ-025 SHALL set halted on the cycle after halt=1 and keep it set until reset; halt has no effect while redirect_valid=1 in the same cycle.
REQ-026 SHALL increment fetch_count only on cycles where IF/ID loads with valid=1; the counter wraps modulo 2^32.
REQ-027 SHALL make all outputs except imem_addr registered.

Reset
REQ-028 SHALL, on a posedge with reset=1, load PC=RESET_PC, if_id_pc=0, if_id_pc_plus4=0, if_id_inst=NOP_INST, if_id_valid=0, halted=0, fetch_count=0.
REQ-029 SHALL give reset priority over stall, flush, redirect_valid and halt; reset mid-stall or mid-halt SHALL restart fetch at RESET_PC.
REQ-030 SHALL make the first valid IF/ID entry appear one cycle after reset deasserts, with if_id_pc=RESET_PC.

Verification
REQ-031 SHALL cover sequential fetch: reset, then 4 free cycles with imem holding I0..I3 at 0x0..0xC -> if_id_pc 0,4,8,C, if_id_inst I0..I3, valid=1, fetch_count=4.
REQ-032 SHALL cover stall: stall=1 for 2 cycles at PC=0x8 -> imem_addr stays 0x8, IF/ID holds pc=0x4, fetch_count is unchanged, and fetch resumes at 0x8.
REQ-033 SHALL cover redirect with simultaneous stall: redirect_valid=1, redirect_pc=0x43, stall=1 -> next PC=0x40, IF/ID valid=0, and next cycle if_id_pc=0x40 with valid=1.
REQ-034 SHALL cover wrap: PC redirected to 0xFFFF_FFFC, free run -> following PC=0x0000_0000.
REQ-035 SHALL cover halt then reset: halt=1 at PC=0x10 -> halted=1, PC frozen, valid=0 forever; reset=1 -> PC=RESET_PC, halted=0, fetch_count=0.
